bcd_countdown_timer: RTL and testbench

Four-digit BCD mm:ss countdown timer that drives the seven-segment digit buses and end-of-count indication in the lab5 timer datapath. It is the producer of the digit values that the LED/stop logic downstream consumes: it loads a preset, counts down once per 1 Hz enable tick under start/pause control, and halts at 00:00 with `done` asserted. The block is fully synchronous to the global clock. All time-base generation (1 Hz divider) and push-button debouncing/one-pulse logic live outside the block.

---
 rtl/bcd_countdown_timer.sv | 129 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Purpose  : Four-digit BCD mm:ss countdown timer. Loads a preset, counts
//            down once per tick while running, and halts at 00:00 with done.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            tick             - 1 Hz enable pulse
//            start_pause      - start/pause toggle pulse
//            load             - load-preset pulse
//            preset_min/sec   - BCD preset {tens, ones}, sampled on load
//            q_out0..q_out3   - sec ones, sec tens, min ones, min tens
//            running, done    - state decodes (RUN, DONE)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
  parameter logic [7:0] INIT_MIN = 8'h01,
  parameter logic [7:0] INIT_SEC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [3:0] q_out0,
  output logic [3:0] q_out1,
  output logic [3:0] q_out2,
  output logic [3:0] q_out3,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] d0_nxt, d1_nxt, d2_nxt, d3_nxt;

  // Decremented count and borrow chain
  logic [3:0] dec0, dec1, dec2, dec3;
  logic       b0, b1, b2;
  logic       count_zero, count_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

  always_comb begin
    b0   = (d0 == 4'd0);
    dec0 = b0 ? 4'd9 : d0 - 4'd1;
    b1   = b0 && (d1 == 4'd0);
    dec1 = b0 ? ((d1 == 4'd0) ? 4'd5 : d1 - 4'd1) : d1;
    b2   = b1 && (d2 == 4'd0);
    dec2 = b1 ? ((d2 == 4'd0) ? 4'd9 : d2 - 4'd1) : d2;
    // Tens of minutes never wraps: a borrow out of it only happens at 00:00,
    // which is never decremented.
    dec3 = b2 ? d3 - 4'd1 : d3;
  end

  assign count_zero = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
  assign count_one  = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd1);

  always_comb begin
    state_nxt = state;
    d0_nxt    = d0;
    d1_nxt    = d1;
    d2_nxt    = d2;
    d3_nxt    = d3;
    if (load) begin
      d0_nxt    = clamp(preset_sec[3:0], 4'd9);
      d1_nxt    = clamp(preset_sec[7:4], 4'd5);
      d2_nxt    = clamp(preset_min[3:0], 4'd9);
      d3_nxt    = clamp(preset_min[7:4], 4'd9);
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_pause) state_nxt = count_zero ? DONE : RUN;
        end
        RUN: begin
          if (start_pause) state_nxt = PAUSE;
          if (tick && !count_zero) begin
            d0_nxt = dec0;
            d1_nxt = dec1;
            d2_nxt = dec2;
            d3_nxt = dec3;
            // Reaching 00:00 wins over a simultaneous pause request.
            if (count_one) state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (start_pause) state_nxt = RUN;
        end
        default: ; // DONE: only load or reset leave it
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d0    <= INIT_SEC[3:0];
      d1    <= INIT_SEC[7:4];
      d2    <= INIT_MIN[3:0];
      d3    <= INIT_MIN[7:4];
    end else begin
      state <= state_nxt;
      d0    <= d0_nxt;
      d1    <= d1_nxt;
      d2    <= d2_nxt;
      d3    <= d3_nxt;
    end
  end

  assign q_out0  = d0;
  assign q_out1  = d1;
  assign q_out2  = d2;
  assign q_out3  = d3;
  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Purpose  : Self-checking bench for bcd_countdown_timer. Each scenario task
//            holds a table of per-cycle stimulus with the expected display
//            {mm:ss, running, done} after that edge; the expectation is queued
//            when the stimulus is driven and popped once the DUT has updated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start_pause = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [3:0] q_out0, q_out1, q_out2, q_out3;
  logic       running, done;

  always #5 clk = ~clk;

  bcd_countdown_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_pause(start_pause),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .q_out0     (q_out0),
    .q_out1     (q_out1),
    .q_out2     (q_out2),
    .q_out3     (q_out3),
    .running    (running),
    .done       (done)
  );

  typedef struct {
    logic        rst, tk, sp, ld;
    logic [7:0]  pm, ps;
    logic [15:0] dig;
    logic        run, dn;
  } step_t;

  typedef struct {
    logic [15:0] dig;
    logic        run, dn;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic step_t mk(logic rst, logic tk, logic sp, logic ld,
                               logic [7:0] pm, logic [7:0] ps,
                               logic [15:0] dig, logic run, logic dn);
    step_t s;
    s.rst = rst; s.tk = tk; s.sp = sp; s.ld = ld;
    s.pm = pm; s.ps = ps; s.dig = dig; s.run = run; s.dn = dn;
    return s;
  endfunction

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic apply(input step_t s);
    reset = s.rst; tick = s.tk; start_pause = s.sp; load = s.ld;
    preset_min = s.pm; preset_sec = s.ps;
    @(posedge clk);
    #1;
    reset = 1'b0; tick = 1'b0; start_pause = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1,0,0,0, 8'h00,8'h00, 16'h0100,0,0));
    st.push_back(mk(1,1,1,0, 8'h00,8'h00, 16'h0100,0,0));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL reset[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_countdown();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0,0,0,1, 8'h00,8'h03, 16'h0003,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0003,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0002,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0001,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0000,0,1));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL countdown[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_borrow();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0,0,0,1, 8'h10,8'h00, 16'h1000,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h1000,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0959,1,0));
    st.push_back(mk(0,0,0,1, 8'h01,8'h00, 16'h0100,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0100,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0059,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0058,1,0));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL borrow[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_pause();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0,0,0,1, 8'h00,8'h10, 16'h0010,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0010,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0009,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0008,1,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0008,0,0));
    for (int k = 0; k < 5; k++)
      st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0008,0,0));
    st.push_back(mk(0,1,1,0, 8'h00,8'h00, 16'h0008,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0007,1,0));
    // Pause and tick together while running: decrement and pause
    st.push_back(mk(0,1,1,0, 8'h00,8'h00, 16'h0006,0,0));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL pause[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_priority();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0006,1,0));
    st.push_back(mk(0,1,1,1, 8'h02,8'h30, 16'h0230,0,0));
    st.push_back(mk(0,0,0,1, 8'hA7,8'h7C, 16'h9759,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h9759,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h9758,1,0));
    st.push_back(mk(0,0,0,1, 8'h00,8'h00, 16'h0000,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,1,1,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,0,0,1, 8'h00,8'h05, 16'h0005,0,0));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL priority[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0,0,0,1, 8'h00,8'h45, 16'h0045,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0045,1,0));
    st.push_back(mk(1,1,0,0, 8'h00,8'h00, 16'h0100,0,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0100,0,0));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    // start_pause held two cycles: RUN then PAUSE
    st.push_back(mk(0,0,0,1, 8'h01,8'h00, 16'h0100,0,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0100,1,0));
    st.push_back(mk(0,0,1,0, 8'h00,8'h00, 16'h0100,0,0));
    // tick tied high: ignored in IDLE, then one step per clock
    st.push_back(mk(0,1,0,1, 8'h00,8'h02, 16'h0002,0,0));
    st.push_back(mk(0,1,1,0, 8'h00,8'h00, 16'h0002,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0001,1,0));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0000,0,1));
    st.push_back(mk(0,1,0,0, 8'h00,8'h00, 16'h0000,0,1));
    foreach (st[i]) begin
      sb.push_back('{dig: st[i].dig, run: st[i].run, dn: st[i].dn});
      apply(st[i]);
      e = sb.pop_front();
      total++;
      if ({q_out3,q_out2,q_out1,q_out0,running,done} !== {e.dig,e.run,e.dn}) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h run=%b done=%b, want %h run=%b done=%b",
                 i, {q_out3,q_out2,q_out1,q_out0}, running, done, e.dig, e.run, e.dn);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
